// File: rtl/day_clock_pkg.sv
// Shared constants and types for the minute-of-day timekeeper.
package day_clock_pkg;

  localparam int DEF_TIME_W   = 11;
  localparam int DEF_DAY_LEN  = 1440;
  localparam int DEF_HOLD_MIN = 360;

  typedef logic [DEF_TIME_W-1:0] minute_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle minute ticks; the counter only advances while enabled
// and clears on clr so a freshly loaded minute starts from a full count.
module tick_prescaler #(
  parameter int TICKS_PER_MIN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MIN - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/day_clock.sv
// Minute-of-day counter with day-end pulse, held day_reset level, day count and
// optional per-channel alarms (compare logic present only with DAY_CLOCK_ALARM_EN).
module day_clock
  import day_clock_pkg::*;
#(
  parameter int TIME_W        = DEF_TIME_W,
  parameter int DAY_W         = 8,
  parameter int TICKS_PER_MIN = 1,
  parameter int HOLD_MIN      = DEF_HOLD_MIN,
  parameter int NUM_ALARMS    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [TIME_W-1:0]            day_len,
  input  logic                         set_valid,
  input  logic [TIME_W-1:0]            set_time,
  input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
  input  logic [NUM_ALARMS-1:0]        alarm_en,
  output logic [TIME_W-1:0]            time_out,
  output logic                         day_end,
  output logic                         day_reset,
  output logic [DAY_W-1:0]             day_count,
  output logic [NUM_ALARMS-1:0]        alarm_hit
);

  localparam logic [TIME_W-1:0] MIN_LEN = TIME_W'(2);
  // A hold minute beyond the counter range can never be reached, so day_reset then stays high.
  localparam bit                HOLD_REACHABLE = (HOLD_MIN < (1 << TIME_W));
  localparam logic [TIME_W-1:0] HOLD_T = TIME_W'(HOLD_MIN);

  logic              tick;
  logic              advance;
  logic              wrap;
  logic [TIME_W-1:0] eff_len;
  logic [TIME_W-1:0] last_min;
  logic [TIME_W-1:0] next_time;

  tick_prescaler #(
    .TICKS_PER_MIN(TICKS_PER_MIN)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (set_valid),
    .tick(tick)
  );

  assign eff_len   = (day_len < MIN_LEN) ? MIN_LEN : day_len;
  assign last_min  = eff_len - 1'b1;
  assign wrap      = (time_out >= last_min);
  assign next_time = wrap ? '0 : time_out + 1'b1;
  assign advance   = tick && !set_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      time_out  <= '0;
      day_end   <= 1'b0;
      day_reset <= 1'b0;
      day_count <= '0;
    end else begin
      day_end <= 1'b0;
      if (set_valid) begin
        time_out <= (set_time >= eff_len) ? '0 : set_time;
      end else if (advance) begin
        time_out <= next_time;
        if (wrap) begin
          day_end   <= 1'b1;
          day_reset <= 1'b1;
          day_count <= day_count + 1'b1;
        end else if (HOLD_REACHABLE && (next_time == HOLD_T)) begin
          day_reset <= 1'b0;
        end
      end
    end
  end

`ifdef DAY_CLOCK_ALARM_EN
  logic [NUM_ALARMS-1:0] hit_next;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    assign hit_next[i] = alarm_en[i] && (next_time == alarm_time[i*TIME_W +: TIME_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_hit <= '0;
    end else begin
      alarm_hit <= advance ? hit_next : '0;
    end
  end
`else
  logic unused_alarm;

  assign unused_alarm = ^{alarm_time, alarm_en};
  assign alarm_hit    = '0;
`endif

endmodule
